interval_timer: RTL

// - Responder side of the FSM timer handshake: takes start_timer + selector from the

---
 rtl/traffic_pkg.sv | 33 +++
 rtl/tick_prescaler.sv | 29 ++
 rtl/interval_timer.sv | 91 +++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller: selector codes used by the
// traffic-state FSM and this timer, timer state encodings, duration decode.
package traffic_pkg;

  localparam logic [1:0] SEL_BASE = 2'b00;
  localparam logic [1:0] SEL_EXT  = 2'b01;
  localparam logic [1:0] SEL_YEL  = 2'b10;
  localparam logic [1:0] SEL_DBL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    COUNT = 2'b01,
    DONE  = 2'b10
  } timer_state_e;

  // Selected interval length in whole seconds; doubled base tops out at 30.
  function automatic logic [4:0] decode_duration(
    input logic [1:0] sel,
    input logic [3:0] t_base,
    input logic [3:0] t_ext,
    input logic [3:0] t_yel
  );
    logic [4:0] d;
    case (sel)
      SEL_BASE: d = {1'b0, t_base};
      SEL_EXT:  d = {1'b0, t_ext};
      SEL_YEL:  d = {1'b0, t_yel};
      default:  d = {t_base, 1'b0};
    endcase
    return d;
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides the system clock down to a one-second boundary strobe.
// tick is high during the last cycle of each second so that the edge which
// wraps the counter is the second boundary.
module tick_prescaler #(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] LAST = PRE_W'(CLK_HZ - 1);

  logic [PRE_W-1:0] cnt;

  // Count 0..CLK_HZ-1 while enabled; clear restarts the second from zero.
  always_ff @(posedge clk) begin
    if (reset || clear)
      cnt <= '0;
    else if (enable)
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign tick = enable && !clear && (cnt == LAST);

endmodule

// File: rtl/interval_timer.sv
// Interval timer answering the traffic FSM's start_timer request: latches the
// selected duration, counts it down in whole seconds and pulses expired.
module interval_timer
  import traffic_pkg::*;
#(
  parameter int CLK_HZ = 25_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_timer,
  input  logic [1:0] selector,
  input  logic [3:0] t_base,
  input  logic [3:0] t_ext,
  input  logic [3:0] t_yel,
  output logic       expired,
  output logic       busy,
  output logic       sec_tick,
  output logic [4:0] remaining
);

  timer_state_e state, state_d;
  logic [4:0]   rem_d;
  logic         exp_d, tick_d, busy_d;
  logic         sec_boundary;
  logic [4:0]   new_dur;

  assign new_dur = decode_duration(selector, t_base, t_ext, t_yel);

  // The prescaler only runs while counting; a start always begins a fresh second.
  tick_prescaler #(.CLK_HZ(CLK_HZ)) u_pre (
    .clk    (clk),
    .reset  (reset),
    .clear  (start_timer || (state != COUNT)),
    .enable (state == COUNT),
    .tick   (sec_boundary)
  );

  // Next-state and next-output decode; a start overrides whatever the old
  // interval would have done on this edge, including its expiry.
  always_comb begin
    state_d = state;
    rem_d   = remaining;
    exp_d   = 1'b0;
    tick_d  = 1'b0;
    if (start_timer) begin
      rem_d   = new_dur;
      state_d = (new_dur == 5'd0) ? DONE : COUNT;
    end else begin
      case (state)
        COUNT: begin
          if (sec_boundary) begin
            if (remaining == 5'd1) begin
              rem_d   = 5'd0;
              state_d = DONE;
              exp_d   = 1'b1;
            end else begin
              rem_d  = remaining - 5'd1;
              tick_d = 1'b1;
            end
          end
        end
        // A zero-length start lands here with expired still low, so it fires
        // one edge later; a counted interval already fired on entry.
        DONE: begin
          state_d = IDLE;
          exp_d   = !expired;
        end
        default: ;
      endcase
    end
    busy_d = (state_d == COUNT);
  end

  // State and all outputs are registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= 5'd0;
      expired   <= 1'b0;
      busy      <= 1'b0;
      sec_tick  <= 1'b0;
    end else begin
      state     <= state_d;
      remaining <= rem_d;
      expired   <= exp_d;
      busy      <= busy_d;
      sec_tick  <= tick_d;
    end
  end

endmodule
